// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: op codes, data width, FSM states.
// Optional zero flag is enabled by ALU_ARB_ZERO_FLAG_EN in the interface and top.
package alu_pkg;
  localparam int DW = 16;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef struct packed {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } alu_req_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two clients and alu_arbiter.
// rsp_zero exists only when ALU_ARB_ZERO_FLAG_EN is defined.
interface alu_arbiter_if;
  import alu_pkg::*;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_op0, req_op1;
  logic [DW-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_cout;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic          rsp_zero;

  modport slave  (input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
                  output req_ready, rsp_valid, rsp_data, rsp_cout, rsp_zero);
  modport master (output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data, rsp_cout, rsp_zero);
`else
  modport slave  (input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
                  output req_ready, rsp_valid, rsp_data, rsp_cout);
  modport master (output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data, rsp_cout);
`endif
endinterface

// File: rtl/alu_arbiter_alu.sv
// 16-bit combinational ALU: AND/OR/ADD/SUB with carry out of bit 15.
module alu16
  import alu_pkg::*;
(
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] o_o,
  output logic          cout_o
);
  logic [DW:0] sum;

  always_comb begin
    sum    = '0;
    o_o    = '0;
    cout_o = 1'b0;
    case (op_i)
      ALU_AND: o_o = a_i & b_i;
      ALU_OR:  o_o = a_i | b_i;
      ALU_ADD: begin
        sum    = {1'b0, a_i} + {1'b0, b_i};
        o_o    = sum[DW-1:0];
        cout_o = sum[DW];
      end
      default: begin
        // subtract as a + ~b + 1, so carry set means no borrow
        sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{DW{1'b0}}, 1'b1};
        o_o    = sum[DW-1:0];
        cout_o = sum[DW];
      end
    endcase
  end
endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant; pointer holds the last-served index.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output logic       gidx_o
);
  logic ptr_q;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign gidx_o = grant_o[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr_q <= 1'b1;
    else if (accept_i) ptr_q <= gidx_o;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Serializes two clients onto one ALU: IDLE (grant) -> EXEC (compute) -> RESP (hold result).
// Define ALU_ARB_ZERO_FLAG_EN to add the registered rsp_zero flag.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  state_t        state_q, state_d;
  alu_req_t      req_q, req_sel;
  logic          g_q;
  logic [1:0]    grant;
  logic          gidx, accept, idle;
  logic [DW-1:0] alu_o, rsp_data_q;
  logic          alu_cout, rsp_cout_q;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle & (|bus.req_valid);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (bus.req_valid),
    .accept_i (accept),
    .grant_o  (grant),
    .gidx_o   (gidx)
  );

  assign bus.req_ready = idle ? grant : 2'b00;

  always_comb begin
    req_sel = gidx ? '{op: bus.req_op1, a: bus.req_a1, b: bus.req_b1}
                   : '{op: bus.req_op0, a: bus.req_a0, b: bus.req_b0};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready[g_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  alu16 u_alu (
    .op_i   (req_q.op),
    .a_i    (req_q.a),
    .b_i    (req_q.b),
    .o_o    (alu_o),
    .cout_o (alu_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      g_q        <= 1'b0;
      rsp_data_q <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= req_sel;
        g_q   <= gidx;
      end
      if (state_q == ST_EXEC) begin
        rsp_data_q <= alu_o;
        rsp_cout_q <= alu_cout;
      end
    end
  end

`ifdef ALU_ARB_ZERO_FLAG_EN
  logic rsp_zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rsp_zero_q <= 1'b0;
    else if (state_q == ST_EXEC)   rsp_zero_q <= (alu_o == '0);
  end
  assign bus.rsp_zero = rsp_zero_q;
`endif

  assign bus.rsp_valid = (state_q == ST_RESP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cout  = rsp_cout_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter; checks rsp_zero when ALU_ARB_ZERO_FLAG_EN is defined.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();
  alu_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [1:0]  g;
    logic [15:0] d;
    logic        c;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", tag);
  endtask

  task automatic push_exp(input int r, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   s;
    e.g = (r == 1) ? 2'b10 : 2'b01;
    e.c = 1'b0;
    e.d = '0;
    case (op)
      2'b00: e.d = a & b;
      2'b01: e.d = a | b;
      2'b10: begin s = int'(a) + int'(b); e.d = s[15:0]; e.c = (s > 65535); end
      default: begin e.d = a - b; e.c = (a >= b); end
    endcase
    e.z = (e.d == 16'h0000);
    sb.push_back(e);
  endtask

  task automatic take_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      timeout({tag, "_sb_empty"});
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'(e.g));
    check({tag, "_data"},  32'(bus.rsp_data),  32'(e.d));
    check({tag, "_cout"},  32'(bus.rsp_cout),  32'(e.c));
`ifdef ALU_ARB_ZERO_FLAG_EN
    check({tag, "_zero"},  32'(bus.rsp_zero),  32'(e.z));
`endif
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic issue(input string tag, input int r, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    logic [1:0] oh;
    oh = (r == 1) ? 2'b10 : 2'b01;
    bus.req_valid = oh;
    if (r == 1) begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
    else        begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        check({tag, "_grant"}, 32'(bus.req_ready), 32'(oh));
        push_exp(r, op, a, b);
        @(negedge clk);
        bus.req_valid = 2'b00;
        return;
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    timeout({tag, "_accept"});
  endtask

  task automatic wait_rsp(input string tag);
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.rsp_valid != 2'b00) begin
        take_rsp(tag);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    timeout({tag, "_rsp"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] fair_seq [6];
    int         n;
    fair_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    bus.req_op0 = 2'b00; bus.req_a0 = '0; bus.req_b0 = '0;
    bus.req_op1 = 2'b00; bus.req_a1 = '0; bus.req_b1 = '0;

    // reset state
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
    check("rst_rsp_cout",  32'(bus.rsp_cout),  32'h0);
`ifdef ALU_ARB_ZERO_FLAG_EN
    check("rst_rsp_zero",  32'(bus.rsp_zero),  32'h0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // single ADD on requester 0 with 2-cycle latency
    issue("add", 0, 2'b10, 16'h7FFF, 16'h0001);
    #1 check("add_exec_novalid", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    #1 check("add_latency", 32'(bus.rsp_valid), 32'h1);
    wait_rsp("add");

    issue("sub_borrow", 1, 2'b11, 16'h0000, 16'h0001);
    wait_rsp("sub_borrow");
    issue("sub_zero", 0, 2'b11, 16'h1234, 16'h1234);
    wait_rsp("sub_zero");
    issue("and", 1, 2'b00, 16'hF0F0, 16'hFF00);
    wait_rsp("and");
    issue("or", 0, 2'b01, 16'hF0F0, 16'hFF00);
    wait_rsp("or");

    // backpressure on requester 1, which keeps req_valid high; other rsp_ready is ignored
    bus.rsp_ready = 2'b01;
    bus.req_valid = 2'b10;
    bus.req_op1 = 2'b10; bus.req_a1 = 16'hABCD; bus.req_b1 = 16'h00FF;
    #1 check("bp_accept", 32'(bus.req_ready), 32'h2);
    push_exp(1, 2'b10, 16'hABCD, 16'h00FF);
    @(negedge clk);
    #1 check("bp_exec_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'h2);
      check("bp_hold_data",  32'(bus.rsp_data),  32'hACCC);
      check("bp_hold_ready", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
    end
    bus.rsp_ready = 2'b10;
    #1 take_rsp("bp");
    @(negedge clk);
    #1 check("bp_next_accept", 32'(bus.req_ready), 32'h2);
    push_exp(1, 2'b10, 16'hABCD, 16'h00FF);
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    wait_rsp("bp_second");

    // fairness with both requesters continuously valid
    n = 0;
    for (int cyc = 0; cyc < 80 && !(n == 6 && sb.size() == 0); cyc++) begin
      if (n < 6) begin
        bus.req_valid = 2'b11;
        bus.req_op0 = 2'b10; bus.req_a0 = 16'h1000 + 16'(n); bus.req_b0 = 16'(n);
        bus.req_op1 = 2'b11; bus.req_a1 = 16'h2000 + 16'(n); bus.req_b1 = 16'h0001;
      end else begin
        bus.req_valid = 2'b00;
      end
      #1;
      if (bus.rsp_valid != 2'b00) take_rsp("fair_rsp");
      if (bus.req_ready != 2'b00 && n < 6) begin
        check("fair_grant", 32'(bus.req_ready), 32'(fair_seq[n]));
        if (fair_seq[n] == 2'b01) push_exp(0, bus.req_op0, bus.req_a0, bus.req_b0);
        else                      push_exp(1, bus.req_op1, bus.req_a1, bus.req_b1);
        n++;
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    check("fair_count", 32'(n), 32'd6);
    check("fair_drained", 32'(sb.size()), 32'd0);

    // reset during EXEC drops the op and restores the pointer
    issue("rst_op", 0, 2'b10, 16'h0001, 16'h0002);
    rst_n = 1'b0;
    #1;
    check("rstx_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rstx_rsp_data",  32'(bus.rsp_data),  32'h0);
    check("rstx_rsp_cout",  32'(bus.rsp_cout),  32'h0);
    check("rstx_req_ready", 32'(bus.req_ready), 32'h0);
`ifdef ALU_ARB_ZERO_FLAG_EN
    check("rstx_rsp_zero",  32'(bus.rsp_zero),  32'h0);
`endif
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 check("rstx_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_op0 = 2'b11; bus.req_a0 = 16'h0005; bus.req_b0 = 16'h0003;
    bus.req_op1 = 2'b00; bus.req_a1 = 16'hFFFF; bus.req_b1 = 16'hFFFF;
    #1 check("rstx_first_tie", 32'(bus.req_ready), 32'h1);
    push_exp(0, 2'b11, 16'h0005, 16'h0003);
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_rsp("rstx_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
